// File: rtl/itype_issue_pkg.sv
// itype_issue_pkg: shared FSM encoding, opcode constant and instruction field helpers
package itype_issue_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam int RS1_LSB = 15;
  localparam int RD_LSB = 7;
  localparam int OPC_LSB = 0;
  function automatic logic [4:0] rs1_of(input logic [31:0] i);
    return i[RS1_LSB +: 5];
  endfunction
  function automatic logic [4:0] rd_of(input logic [31:0] i);
    return i[RD_LSB +: 5];
  endfunction
  function automatic logic [6:0] opc_of(input logic [31:0] i);
    return i[OPC_LSB +: 7];
  endfunction
endpackage

// File: rtl/itype_issue_regfile.sv
// regfile_32x32: one sync write port, operand and debug comb read ports, x0 hardwired zero
module regfile_32x32 #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [4:0]  daddr,
  output logic [31:0] ddata
);
  logic [31:0] r [N];
  assign rdata = raddr == '0 ? '0 : r[raddr];
  assign ddata = daddr == '0 ? '0 : r[daddr];
  // clear on reset; writes to x0 are dropped so it always reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r[i] <= '0;
    end else if (we && waddr != '0) begin
      r[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/itype_issue.sv
// itype_issue: four-state issue/retire sequencer for RV32 I-type ops around an external ALU
module itype_issue
  import itype_issue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [31:0]     alu_instr,
  output logic [XLEN-1:0] alu_rs1_data,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  output logic            wb_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            busy
);
  state_t state;
  logic [31:0] instr_q;
  logic [XLEN-1:0] op_q, res_q, rs1_rdata;
  assign in_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign alu_instr = instr_q;
  assign alu_rs1_data = op_q;
  regfile_32x32 #(.N(NREGS)) u_rf (
    .clk(clk), .rst(rst),
    .we(state == S_WB && wb_write), .waddr(wb_rd), .wdata(res_q),
    .raddr(rs1_of(instr_q)), .rdata(rs1_rdata),
    .daddr(dbg_addr), .ddata(dbg_data)
  );
  // sequencer: latch, read operand, capture ALU result, retire; the rf write lands as WB ends
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      instr_q <= '0;
      op_q <= '0;
      res_q <= '0;
      wb_valid <= 1'b0;
      wb_write <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          instr_q <= in_instr;
          state <= S_READ;
        end
        S_READ: begin
          op_q <= rs1_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q <= alu_result;
          wb_valid <= 1'b1;
          wb_write <= opc_of(instr_q) == OPCODE_OP_IMM && rd_of(instr_q) != '0;
          wb_rd <= rd_of(instr_q);
          wb_data <= alu_result;
          state <= S_WB;
        end
        default: begin
          wb_valid <= 1'b0;
          wb_write <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
